rvh_pmp_chk_arb: RTL

//  Shares one bank of PMP entries between REQ_N requesters (ITLB, DTLB-ld, DTLB-st, PTW).

---
 rtl/rvh_pmp_pkg.sv | 33 +++
 rtl/rvh_pmp_rr_arb.sv | 70 +++++++
 rtl/rvh_pmp_chk_arb.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/rvh_pmp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : rvh_pmp_pkg                                                   |
// | Purpose    : Shared PMP definitions. It holds the access-type codes used   |
// |              on the check bus, the pmpcfg.A field encodings, and a width   |
// |              helper for requester ids.                                     |
// | Ports      : none (package)                                                |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package rvh_pmp_pkg;

  // Access type carried on req_access_type_i / chk_access_type_o
  typedef logic [1:0] pmp_acc_t;
  localparam pmp_acc_t PMP_ACC_R = 2'd0;
  localparam pmp_acc_t PMP_ACC_W = 2'd1;
  localparam pmp_acc_t PMP_ACC_X = 2'd2;

  // pmpcfg.A address-matching mode
  typedef enum logic [1:0] {
    PMP_A_OFF   = 2'd0,
    PMP_A_TOR   = 2'd1,
    PMP_A_NA4   = 2'd2,
    PMP_A_NAPOT = 2'd3
  } pmp_a_e;

  // Requester id width. This is never narrower than 1 bit, so that a
  // single-requester build still has a legal id port.
  function automatic int pmp_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rvh_pmp_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : rvh_pmp_rr_arb                                                |
// | Purpose    : REQ_N-wide round-robin arbiter. The search starts at the      |
// |              rr pointer. After a grant to r, the pointer moves to          |
// |              (r+1) mod REQ_N.                                              |
// | Ports      : clk, rstn        clock / async active-low reset               |
// |              en_i             arbitration allowed this cycle               |
// |              req_i   [REQ_N]  request vector                               |
// |              gnt_o   [REQ_N]  one-hot grant (zero when none or !en_i)      |
// |              gnt_vld_o        any grant issued                             |
// |              gnt_id_o [ID_W]  index of the granted requester               |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module rvh_pmp_rr_arb
  import rvh_pmp_pkg::*;
#(
  parameter  int REQ_N = 4,
  localparam int ID_W  = pmp_id_w(REQ_N)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en_i,
  input  logic [REQ_N-1:0] req_i,
  output logic [REQ_N-1:0] gnt_o,
  output logic            gnt_vld_o,
  output logic [ID_W-1:0] gnt_id_o
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            found;
  logic [ID_W-1:0] win_id;

  // Index at position k of the search that starts at base, wrapping at REQ_N
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
    return ID_W'((int'(base) + k) % REQ_N);
  endfunction

  always_comb begin
    found  = 1'b0;
    win_id = '0;
    for (int k = 0; k < REQ_N; k++) begin
      if (!found && req_i[rr_idx(ptr_q, k)]) begin
        found  = 1'b1;
        win_id = rr_idx(ptr_q, k);
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    for (int r = 0; r < REQ_N; r++) begin
      gnt_o[r] = en_i & found & (win_id == ID_W'(r));
    end
  end

  assign gnt_vld_o = en_i & found;
  assign gnt_id_o  = win_id;
  assign ptr_d     = rr_idx(win_id, 1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else if (gnt_vld_o) begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rvh_pmp_chk_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : rvh_pmp_chk_arb                                               |
// | Purpose    : Shares one PMP entry bank between REQ_N requesters (ITLB,     |
// |              DTLB-ld, DTLB-st, PTW). It has three stages:                  |
// |                S0 round-robin arbitration                                  |
// |                S1 check register, which drives chk_* to all entries        |
// |                S2 response register, which holds pass/fail and the id      |
// |              Fail is resolved in S1 from the lowest-index matching entry,  |
// |              with the M-mode/lock rule applied.                            |
// | Ports      : clk, rstn                    clock / async active-low reset   |
// |              req_vld/paddr/access_type/priv_m_i   requester side          |
// |              req_rdy_o                    one-hot accept                   |
// |              chk_vld/paddr/access_type_o  broadcast to the entry bank      |
// |              entry_match/fail/lock/active_i  per-entry results             |
// |              resp_vld_o, resp_id_o, resp_fail_o, resp_rdy_i  response      |
// | Options    : RVH_PMP_CHK_FAIL_CNT_EN adds two ports:                       |
// |                fail_cnt_clr_i  clears the counter                          |
// |                fail_cnt_o      saturating 32-bit count of failing          |
// |                                responses                                   |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module rvh_pmp_chk_arb
  import rvh_pmp_pkg::*;
#(
  parameter  int PADDR_WIDTH = 56,
  parameter  int ENTRY_N     = 16,
  parameter  int REQ_N       = 4,
  localparam int ID_W        = pmp_id_w(REQ_N)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [REQ_N-1:0]             req_vld_i,
  input  logic [REQ_N*PADDR_WIDTH-1:0] req_paddr_i,
  input  logic [REQ_N*2-1:0]           req_access_type_i,
  input  logic [REQ_N-1:0]             req_priv_m_i,
  output logic [REQ_N-1:0]             req_rdy_o,
  output logic                         chk_vld_o,
  output logic [PADDR_WIDTH-1:0]       chk_paddr_o,
  output logic [1:0]                   chk_access_type_o,
  input  logic [ENTRY_N-1:0]           entry_match_i,
  input  logic [ENTRY_N-1:0]           entry_fail_i,
  input  logic [ENTRY_N-1:0]           entry_lock_i,
  input  logic [ENTRY_N-1:0]           entry_active_i,
  output logic                         resp_vld_o,
  output logic [ID_W-1:0]              resp_id_o,
  output logic                         resp_fail_o,
  input  logic                         resp_rdy_i
`ifdef RVH_PMP_CHK_FAIL_CNT_EN
  ,
  input  logic                         fail_cnt_clr_i,
  output logic [31:0]                  fail_cnt_o
`endif
);

  // --------------------------------------------------------------------------
  // Stage advance. S2 frees up when it is empty or being drained. S1 moves
  // whenever S2 takes it, so a drain and a refill in the same cycle leave no
  // bubble.
  // --------------------------------------------------------------------------
  logic s1_vld_q, s1_vld_d;
  logic s2_vld_q, s2_vld_d;
  logic s2_adv, s1_adv, arb_en;

  assign s2_adv = ~s2_vld_q | resp_rdy_i;
  assign s1_adv = s2_adv | ~s1_vld_q;
  // Gating with rstn keeps req_rdy_o low while reset is held.
  assign arb_en = s1_adv & rstn;

  // --------------------------------------------------------------------------
  // S0: arbitration and request select
  // --------------------------------------------------------------------------
  logic            gnt_vld;
  logic [ID_W-1:0] gnt_id;

  rvh_pmp_rr_arb #(
    .REQ_N (REQ_N)
  ) u_rr_arb (
    .clk       (clk),
    .rstn      (rstn),
    .en_i      (arb_en),
    .req_i     (req_vld_i),
    .gnt_o     (req_rdy_o),
    .gnt_vld_o (gnt_vld),
    .gnt_id_o  (gnt_id)
  );

  logic [PADDR_WIDTH-1:0] s1_paddr_q, s1_paddr_d;
  pmp_acc_t               s1_acc_q, s1_acc_d;
  logic                   s1_priv_m_q, s1_priv_m_d;
  logic [ID_W-1:0]        s1_id_q, s1_id_d;

  always_comb begin
    s1_paddr_d  = '0;
    s1_acc_d    = PMP_ACC_R;
    s1_priv_m_d = 1'b0;
    for (int r = 0; r < REQ_N; r++) begin
      if (gnt_id == ID_W'(r)) begin
        s1_paddr_d  = req_paddr_i[r*PADDR_WIDTH +: PADDR_WIDTH];
        s1_acc_d    = req_access_type_i[r*2 +: 2];
        s1_priv_m_d = req_priv_m_i[r];
      end
    end
    s1_id_d  = gnt_id;
    s1_vld_d = gnt_vld;
  end

  // --------------------------------------------------------------------------
  // S1 register. The payload loads only on a grant, so chk_* stays stable
  // while S1 stalls or drains.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld_q    <= 1'b0;
      s1_paddr_q  <= '0;
      s1_acc_q    <= PMP_ACC_R;
      s1_priv_m_q <= 1'b0;
      s1_id_q     <= '0;
    end else begin
      if (s1_adv) s1_vld_q <= s1_vld_d;
      if (gnt_vld) begin
        s1_paddr_q  <= s1_paddr_d;
        s1_acc_q    <= s1_acc_d;
        s1_priv_m_q <= s1_priv_m_d;
        s1_id_q     <= s1_id_d;
      end
    end
  end

  assign chk_vld_o         = s1_vld_q;
  assign chk_paddr_o       = s1_paddr_q;
  assign chk_access_type_o = s1_acc_q;

  // --------------------------------------------------------------------------
  // S1 resolution. The lowest-index matching entry decides the result. M-mode
  // is only restricted by locked entries. With no match, the access fails for
  // S/U-mode when any entry is active.
  // --------------------------------------------------------------------------
  logic hit, hit_fail, hit_lock, s1_fail;

  always_comb begin
    hit      = 1'b0;
    hit_fail = 1'b0;
    hit_lock = 1'b0;
    for (int e = 0; e < ENTRY_N; e++) begin
      if (!hit && entry_match_i[e]) begin
        hit      = 1'b1;
        hit_fail = entry_fail_i[e];
        hit_lock = entry_lock_i[e];
      end
    end
  end

  always_comb begin
    if (hit) begin
      s1_fail = s1_priv_m_q ? (hit_lock & hit_fail) : hit_fail;
    end else begin
      s1_fail = ~s1_priv_m_q & (|entry_active_i);
    end
  end

  // --------------------------------------------------------------------------
  // S2 response register
  // --------------------------------------------------------------------------
  logic [ID_W-1:0] s2_id_q, s2_id_d;
  logic            s2_fail_q, s2_fail_d;

  assign s2_vld_d  = s1_vld_q;
  assign s2_id_d   = s1_id_q;
  assign s2_fail_d = s1_fail;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_vld_q  <= 1'b0;
      s2_id_q   <= '0;
      s2_fail_q <= 1'b0;
    end else if (s2_adv) begin
      s2_vld_q <= s2_vld_d;
      if (s1_vld_q) begin
        s2_id_q   <= s2_id_d;
        s2_fail_q <= s2_fail_d;
      end
    end
  end

  assign resp_vld_o  = s2_vld_q;
  assign resp_id_o   = s2_id_q;
  assign resp_fail_o = s2_fail_q;

`ifdef RVH_PMP_CHK_FAIL_CNT_EN
  // --------------------------------------------------------------------------
  // Saturating failure counter. A clear beats a same-cycle increment.
  // --------------------------------------------------------------------------
  logic [31:0] fail_cnt_q, fail_cnt_d;

  always_comb begin
    fail_cnt_d = fail_cnt_q;
    if (fail_cnt_clr_i) begin
      fail_cnt_d = '0;
    end else if (resp_vld_o && resp_rdy_i && resp_fail_o && !(&fail_cnt_q)) begin
      fail_cnt_d = fail_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) fail_cnt_q <= '0;
    else       fail_cnt_q <= fail_cnt_d;
  end

  assign fail_cnt_o = fail_cnt_q;
`endif

endmodule
`default_nettype wire
